// File: rtl/i2s_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_deser
// Purpose  : I2S (Philips) receive deserializer with 2-entry output FIFO.
//            Optional macro I2S_RX_ERR_CNT_EN enables the dropped-word counter.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx_deser (
    input  logic        sck_i,
    input  logic        rstn_i,
    input  logic        cfg_en_i,
    input  logic [4:0]  cfg_data_size_i,
    input  logic        cfg_lsb_first_i,
    input  logic        cfg_2ch_i,
    input  logic        i2s_ws_i,
    input  logic        i2s_sd_i,
    output logic [31:0] data_o,
    output logic        data_ch_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic        overflow_o,
    output logic        framing_err_o,
    output logic [15:0] err_cnt_o
);

    localparam logic [4:0] C_CNT_MAX = 5'd31;
    localparam logic [1:0] C_DEPTH   = 2'd2;

    logic        r_ws_q;
    logic        r_synced;
    logic [4:0]  r_bit_cnt;
    logic [31:0] r_shift;
    logic [32:0] r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        r_overflow;
    logic        r_framing_err;

    logic        w_boundary;
    logic [31:0] w_shift_next;
    logic        w_keep;
    logic        w_word_end;
    logic        w_len_ok;
    logic        w_push_req;
    logic        w_frame_err;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_overflow;

    // The bit sampled on the boundary edge belongs to the word that ends there,
    // so the completed word is taken from the next-state shift value.
    always_comb begin
        w_boundary   = (i2s_ws_i != r_ws_q);
        w_shift_next = r_shift;
        if (r_bit_cnt <= cfg_data_size_i) begin
            if (cfg_lsb_first_i) begin
                w_shift_next[r_bit_cnt] = i2s_sd_i;
            end else begin
                w_shift_next = {r_shift[30:0], i2s_sd_i};
            end
        end
        w_keep      = cfg_2ch_i | ~r_ws_q;
        w_word_end  = cfg_en_i & r_synced & w_boundary & w_keep;
        w_len_ok    = (r_bit_cnt == cfg_data_size_i);
        w_push_req  = w_word_end & w_len_ok;
        w_frame_err = w_word_end & ~w_len_ok;
        w_full      = (r_count == C_DEPTH);
        w_pop       = data_valid_o & data_ready_i;
        w_push      = w_push_req & (~w_full | w_pop);
        w_overflow  = w_push_req & w_full & ~w_pop;
    end

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ws_q    <= 1'b0;
            r_synced  <= 1'b0;
            r_bit_cnt <= 5'd0;
            r_shift   <= 32'd0;
        end else begin
            r_ws_q <= i2s_ws_i;
            if (!cfg_en_i) begin
                r_synced  <= 1'b0;
                r_bit_cnt <= 5'd0;
                r_shift   <= 32'd0;
            end else if (w_boundary) begin
                r_synced  <= 1'b1;
                r_bit_cnt <= 5'd0;
                r_shift   <= 32'd0;
            end else begin
                if (r_bit_cnt != C_CNT_MAX) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
                r_shift <= w_shift_next;
            end
        end
    end

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= 33'd0;
            end
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_overflow    <= 1'b0;
            r_framing_err <= 1'b0;
        end else if (!cfg_en_i) begin
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_overflow    <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            r_overflow    <= w_overflow;
            r_framing_err <= w_frame_err;
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_ws_q, w_shift_next};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is gated so a flushed or empty FIFO presents zeros.
    always_comb begin
        data_valid_o = (r_count != 2'd0);
        {data_ch_o, data_o} = data_valid_o ? r_mem[r_rd_ptr] : 33'd0;
    end

    assign overflow_o    = r_overflow;
    assign framing_err_o = r_framing_err;

`ifdef I2S_RX_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_err_cnt <= 16'd0;
        end else if (!cfg_en_i) begin
            r_err_cnt <= 16'd0;
        end else if ((w_overflow | w_frame_err) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx_deser
// Purpose  : Directed self-checking bench for i2s_rx_deser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_deser;

    logic        sck_i = 1'b0;
    logic        rstn_i;
    logic        cfg_en_i;
    logic [4:0]  cfg_data_size_i;
    logic        cfg_lsb_first_i;
    logic        cfg_2ch_i;
    logic        i2s_ws_i;
    logic        i2s_sd_i;
    logic [31:0] data_o;
    logic        data_ch_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        overflow_o;
    logic        framing_err_o;
    logic [15:0] err_cnt_o;

    int n_vec = 0;
    int n_err = 0;

`ifdef I2S_RX_ERR_CNT_EN
    localparam logic [31:0] C_ERR1 = 32'd1;
`else
    localparam logic [31:0] C_ERR1 = 32'd0;
`endif

    i2s_rx_deser u_dut (
        .sck_i           (sck_i),
        .rstn_i          (rstn_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_data_size_i (cfg_data_size_i),
        .cfg_lsb_first_i (cfg_lsb_first_i),
        .cfg_2ch_i       (cfg_2ch_i),
        .i2s_ws_i        (i2s_ws_i),
        .i2s_sd_i        (i2s_sd_i),
        .data_o          (data_o),
        .data_ch_o       (data_ch_o),
        .data_valid_o    (data_valid_o),
        .data_ready_i    (data_ready_i),
        .overflow_o      (overflow_o),
        .framing_err_o   (framing_err_o),
        .err_cnt_o       (err_cnt_o)
    );

    always #5 sck_i = ~sck_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One SCK period: drive ws/sd, let the rising edge sample them, settle.
    task automatic clk_bit(input logic ws, input logic sd);
        i2s_ws_i = ws;
        i2s_sd_i = sd;
        @(posedge sck_i);
        #1;
    endtask

    // Philips framing: ws already equals ch; the last bit goes out with ws=nxt.
    task automatic send_word(input logic ch, input logic [31:0] d, input int len,
                             input logic lsb, input logic nxt, input logic rdy_last);
        for (int i = 0; i < len; i++) begin
            if (i == len - 1 && rdy_last) data_ready_i = 1'b1;
            clk_bit((i == len - 1) ? nxt : ch, lsb ? d[i] : d[len - 1 - i]);
        end
    endtask

    // Flush, reconfigure, then a ws 1->0 boundary that only arms sync.
    task automatic start_stream(input logic [4:0] size, input logic lsb, input logic two_ch);
        cfg_en_i = 1'b0;
        clk_bit(1'b1, 1'b0);
        clk_bit(1'b1, 1'b0);
        cfg_data_size_i = size;
        cfg_lsb_first_i = lsb;
        cfg_2ch_i       = two_ch;
        cfg_en_i        = 1'b1;
        clk_bit(1'b0, 1'b0);
    endtask

    initial begin
        rstn_i          = 1'b0;
        cfg_en_i        = 1'b0;
        cfg_data_size_i = 5'd15;
        cfg_lsb_first_i = 1'b0;
        cfg_2ch_i       = 1'b1;
        i2s_ws_i        = 1'b0;
        i2s_sd_i        = 1'b0;
        data_ready_i    = 1'b1;
        repeat (2) @(posedge sck_i);
        #1;
        chk("rst_data",  data_o, 32'd0);
        chk("rst_ch",    {31'd0, data_ch_o}, 32'd0);
        chk("rst_valid", {31'd0, data_valid_o}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow_o}, 32'd0);
        chk("rst_ferr",  {31'd0, framing_err_o}, 32'd0);
        chk("rst_cnt",   {16'd0, err_cnt_o}, 32'd0);
        rstn_i = 1'b1;

        // Stereo, 16-bit MSB-first
        start_stream(5'd15, 1'b0, 1'b1);
        chk("sync_no_word", {31'd0, data_valid_o}, 32'd0);
        send_word(1'b0, 32'hA5C3, 16, 1'b0, 1'b1, 1'b0);
        chk("st_l_valid", {31'd0, data_valid_o}, 32'd1);
        chk("st_l_data",  data_o, 32'h0000A5C3);
        chk("st_l_ch",    {31'd0, data_ch_o}, 32'd0);
        send_word(1'b1, 32'h1234, 16, 1'b0, 1'b0, 1'b0);
        chk("st_r_data",  data_o, 32'h00001234);
        chk("st_r_ch",    {31'd0, data_ch_o}, 32'd1);
        clk_bit(1'b0, 1'b0);
        chk("st_popped",  {31'd0, data_valid_o}, 32'd0);

        // LSB-first, 8 and 32 bits
        start_stream(5'd7, 1'b1, 1'b1);
        send_word(1'b0, 32'h81, 8, 1'b1, 1'b1, 1'b0);
        chk("lsb8_a", data_o, 32'h00000081);
        send_word(1'b1, 32'h1E, 8, 1'b1, 1'b0, 1'b0);
        chk("lsb8_b", data_o, 32'h0000001E);
        start_stream(5'd31, 1'b1, 1'b1);
        send_word(1'b0, 32'hDEADBEEF, 32, 1'b1, 1'b1, 1'b0);
        chk("lsb32", data_o, 32'hDEADBEEF);

        // Mono: right words vanish silently
        start_stream(5'd7, 1'b0, 1'b0);
        for (int f = 0; f < 4; f++) begin
            send_word(1'b0, 32'hC1 + f, 8, 1'b0, 1'b1, 1'b0);
            chk("mono_l_valid", {31'd0, data_valid_o}, 32'd1);
            chk("mono_l_data",  data_o, 32'hC1 + f);
            chk("mono_l_ch",    {31'd0, data_ch_o}, 32'd0);
            send_word(1'b1, 32'h5A, 8, 1'b0, 1'b0, 1'b0);
            chk("mono_r_none",  {31'd0, data_valid_o}, 32'd0);
            chk("mono_r_ferr",  {31'd0, framing_err_o}, 32'd0);
        end
        chk("mono_cnt", {16'd0, err_cnt_o}, 32'd0);

        // Backpressure and overflow
        data_ready_i = 1'b0;
        start_stream(5'd7, 1'b0, 1'b1);
        send_word(1'b0, 32'h11, 8, 1'b0, 1'b1, 1'b0);
        chk("bp_a", data_o, 32'h11);
        send_word(1'b1, 32'h22, 8, 1'b0, 1'b0, 1'b0);
        chk("bp_hold_a",  data_o, 32'h11);
        chk("bp_no_ovf",  {31'd0, overflow_o}, 32'd0);
        send_word(1'b0, 32'h33, 8, 1'b0, 1'b1, 1'b0);
        chk("bp_ovf",     {31'd0, overflow_o}, 32'd1);
        chk("bp_ovf_cnt", {16'd0, err_cnt_o}, C_ERR1);
        chk("bp_hold_a2", data_o, 32'h11);
        send_word(1'b1, 32'h44, 8, 1'b0, 1'b0, 1'b1);
        chk("bp_pp_ovf",  {31'd0, overflow_o}, 32'd0);
        chk("bp_pp_b",    data_o, 32'h22);
        chk("bp_pp_bch",  {31'd0, data_ch_o}, 32'd1);
        chk("bp_pp_cnt",  {16'd0, err_cnt_o}, C_ERR1);
        clk_bit(1'b0, 1'b0);
        chk("bp_d",       data_o, 32'h44);
        clk_bit(1'b0, 1'b0);
        chk("bp_empty",   {31'd0, data_valid_o}, 32'd0);

        // Framing error: early ws toggle after 10 bits
        start_stream(5'd15, 1'b0, 1'b1);
        chk("fe_cnt_clr", {16'd0, err_cnt_o}, 32'd0);
        send_word(1'b0, 32'h3FF, 10, 1'b0, 1'b1, 1'b0);
        chk("fe_pulse",   {31'd0, framing_err_o}, 32'd1);
        chk("fe_no_push", {31'd0, data_valid_o}, 32'd0);
        chk("fe_cnt",     {16'd0, err_cnt_o}, C_ERR1);
        send_word(1'b1, 32'hBEEF, 16, 1'b0, 1'b0, 1'b0);
        chk("fe_next",    data_o, 32'h0000BEEF);
        chk("fe_next_ch", {31'd0, data_ch_o}, 32'd1);
        chk("fe_clear",   {31'd0, framing_err_o}, 32'd0);

        // Asynchronous reset mid-word with FIFO occupied
        data_ready_i = 1'b0;
        start_stream(5'd7, 1'b0, 1'b1);
        send_word(1'b0, 32'h5A, 8, 1'b0, 1'b1, 1'b0);
        chk("ar_pre_valid", {31'd0, data_valid_o}, 32'd1);
        clk_bit(1'b1, 1'b1);
        clk_bit(1'b1, 1'b0);
        clk_bit(1'b1, 1'b1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("ar_valid", {31'd0, data_valid_o}, 32'd0);
        chk("ar_data",  data_o, 32'd0);
        chk("ar_ch",    {31'd0, data_ch_o}, 32'd0);
        chk("ar_ovf",   {31'd0, overflow_o}, 32'd0);
        chk("ar_ferr",  {31'd0, framing_err_o}, 32'd0);
        chk("ar_cnt",   {16'd0, err_cnt_o}, 32'd0);
        @(posedge sck_i);
        #1;
        rstn_i = 1'b1;

        // Enable toggle with FIFO non-empty, then re-sync
        start_stream(5'd7, 1'b0, 1'b1);
        send_word(1'b0, 32'h6B, 8, 1'b0, 1'b1, 1'b0);
        chk("en_pre_data", data_o, 32'h6B);
        cfg_en_i = 1'b0;
        clk_bit(1'b1, 1'b0);
        chk("en_flush_valid", {31'd0, data_valid_o}, 32'd0);
        chk("en_flush_data",  data_o, 32'd0);
        cfg_en_i = 1'b1;
        send_word(1'b1, 32'h77, 8, 1'b0, 1'b0, 1'b0);
        chk("en_sync_drop", {31'd0, data_valid_o}, 32'd0);
        chk("en_sync_ferr", {31'd0, framing_err_o}, 32'd0);
        send_word(1'b0, 32'h99, 8, 1'b0, 1'b1, 1'b0);
        chk("en_resync_data", data_o, 32'h99);
        chk("en_resync_ch",   {31'd0, data_ch_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
